// File: rtl/nes_pad_scheduler.sv
// nes_pad_scheduler: poll timer, request arbitration and latch/clock/shift sequencing for two NES pads.
// Optional build macro PAD_DATA_SYNC_EN adds a 2-flop synchronizer on each pad_data bit.
module nes_pad_scheduler #(
    parameter int POLL_DIV  = 166667,
    parameter int LATCH_CYC = 120,
    parameter int HALF_CYC  = 60
) (
    input  logic       clk_10MHz,
    input  logic       reset,
    input  logic       enable,
    input  logic       force_poll,
    input  logic [1:0] pad_data,
    output logic       pad_latch,
    output logic [1:0] pad_clk,
    output logic [7:0] buttons0,
    output logic [7:0] buttons1,
    output logic [1:0] valid,
    output logic       busy,
    output logic       poll_overrun
);

    localparam int TIMER_W   = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
    localparam int PHASE_MAX = (LATCH_CYC > HALF_CYC) ? LATCH_CYC : HALF_CYC;
    localparam int CNT_W     = $clog2(PHASE_MAX + 1);

    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(POLL_DIV - 1);
    localparam logic [CNT_W-1:0]   LATCH_LAST = CNT_W'(LATCH_CYC - 1);
    localparam logic [CNT_W-1:0]   HALF_LAST  = CNT_W'(HALF_CYC - 1);

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        LOW,
        HIGH,
        DONE
    } state_t;

    state_t             state;
    logic [TIMER_W-1:0] timer;
    logic [CNT_W-1:0]   phase_cnt;
    logic               port_sel;
    logic [2:0]         bit_idx;
    logic [7:0]         shift_reg;
    logic               pending;
    logic [1:0]         pad_sample;
    logic               timer_req;
    logic               req;

`ifdef PAD_DATA_SYNC_EN
    logic [1:0] sync_a;
    logic [1:0] sync_b;

    always_ff @(posedge clk_10MHz or negedge reset) begin
        if (!reset) begin
            sync_a <= 2'b00;
            sync_b <= 2'b00;
        end else begin
            sync_a <= pad_data;
            sync_b <= sync_a;
        end
    end

    assign pad_sample = sync_b;
`else
    assign pad_sample = pad_data;
`endif

    // Timer wrap and force_poll in the same cycle collapse into a single request.
    assign timer_req = enable && (timer == TIMER_LAST);
    assign req       = enable && (timer_req || force_poll);

    always_ff @(posedge clk_10MHz or negedge reset) begin
        if (!reset) begin
            timer <= '0;
        end else if (!enable || timer == TIMER_LAST) begin
            timer <= '0;
        end else begin
            timer <= timer + TIMER_W'(1);
        end
    end

    always_ff @(posedge clk_10MHz or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            phase_cnt    <= '0;
            port_sel     <= 1'b0;
            bit_idx      <= 3'd0;
            shift_reg    <= 8'h00;
            pending      <= 1'b0;
            pad_latch    <= 1'b0;
            pad_clk      <= 2'b00;
            buttons0     <= 8'h00;
            buttons1     <= 8'h00;
            valid        <= 2'b00;
            busy         <= 1'b0;
            poll_overrun <= 1'b0;
        end else begin
            valid        <= 2'b00;
            poll_overrun <= 1'b0;

            // Only one request can wait behind a running poll; a further one is dropped.
            if (req && state != IDLE) begin
                if (pending) begin
                    poll_overrun <= 1'b1;
                end else begin
                    pending <= 1'b1;
                end
            end

            case (state)
                IDLE: begin
                    if (req || pending) begin
                        state     <= LATCH;
                        pad_latch <= 1'b1;
                        busy      <= 1'b1;
                        phase_cnt <= '0;
                    end
                    pending <= 1'b0;
                end

                LATCH: begin
                    if (phase_cnt == LATCH_LAST) begin
                        state     <= LOW;
                        pad_latch <= 1'b0;
                        phase_cnt <= '0;
                        port_sel  <= 1'b0;
                        bit_idx   <= 3'd0;
                    end else begin
                        phase_cnt <= phase_cnt + CNT_W'(1);
                    end
                end

                LOW: begin
                    if (phase_cnt == HALF_LAST) begin
                        shift_reg[bit_idx] <= ~pad_sample[port_sel];
                        state              <= HIGH;
                        pad_clk            <= port_sel ? 2'b10 : 2'b01;
                        phase_cnt          <= '0;
                    end else begin
                        phase_cnt <= phase_cnt + CNT_W'(1);
                    end
                end

                HIGH: begin
                    if (phase_cnt == HALF_LAST) begin
                        pad_clk   <= 2'b00;
                        phase_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            valid[port_sel] <= 1'b1;
                            if (!port_sel) begin
                                buttons0 <= shift_reg;
                                port_sel <= 1'b1;
                                bit_idx  <= 3'd0;
                                state    <= LOW;
                            end else begin
                                buttons1 <= shift_reg;
                                state    <= DONE;
                            end
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            state   <= LOW;
                        end
                    end else begin
                        phase_cnt <= phase_cnt + CNT_W'(1);
                    end
                end

                DONE: begin
                    // A waiting request (or one arriving now) chains straight into the next latch.
                    if (pending || req) begin
                        state     <= LATCH;
                        pad_latch <= 1'b1;
                        phase_cnt <= '0;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                    pending <= 1'b0;
                end

                default: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    pad_latch <= 1'b0;
                    pad_clk   <= 2'b00;
                end
            endcase

            if (!enable) begin
                pending <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_nes_pad_scheduler.sv
// tb_nes_pad_scheduler: directed scenarios with a queue scoreboard checked on every valid strobe.
module tb_nes_pad_scheduler;

    localparam int POLL_DIV  = 5000;
    localparam int LATCH_CYC = 4;
    localparam int HALF_CYC  = 2;
    localparam int V0_LAT    = 1 + LATCH_CYC + 16 * HALF_CYC;
    localparam int V1_LAT    = 1 + LATCH_CYC + 32 * HALF_CYC;

    logic       clk_10MHz  = 1'b0;
    logic       reset      = 1'b1;
    logic       enable     = 1'b0;
    logic       force_poll = 1'b0;
    logic [1:0] pad_data;
    logic       pad_latch;
    logic [1:0] pad_clk;
    logic [7:0] buttons0;
    logic [7:0] buttons1;
    logic [1:0] valid;
    logic       busy;
    logic       poll_overrun;

    int nChecks = 0;
    int nFails  = 0;
    int cyc     = 0;

    typedef struct {
        int         port;
        logic [7:0] value;
        int         cycle;
    } exp_t;

    exp_t expQ[$];

    logic [7:0] pressed0 = 8'h00;
    logic [7:0] pressed1 = 8'h00;
    logic [7:0] sh0      = 8'hFF;
    logic [7:0] sh1      = 8'hFF;
    logic [1:0] padPrev  = 2'b00;
    logic [1:0] monPrev  = 2'b00;

    int rise0        = 0;
    int rise1        = 0;
    int overlapCount = 0;
    int overrunCount = 0;
    int overrunCycle = -1;
    int v1Count      = 0;

    nes_pad_scheduler #(
        .POLL_DIV (POLL_DIV),
        .LATCH_CYC(LATCH_CYC),
        .HALF_CYC (HALF_CYC)
    ) dut (
        .clk_10MHz   (clk_10MHz),
        .reset       (reset),
        .enable      (enable),
        .force_poll  (force_poll),
        .pad_data    (pad_data),
        .pad_latch   (pad_latch),
        .pad_clk     (pad_clk),
        .buttons0    (buttons0),
        .buttons1    (buttons1),
        .valid       (valid),
        .busy        (busy),
        .poll_overrun(poll_overrun)
    );

    always #50 clk_10MHz = ~clk_10MHz;

    always @(posedge clk_10MHz) cyc <= cyc + 1;

    // Two 4021-style pads: latch loads inverted buttons, each rising pad clock shifts in a 1.
    always @(negedge clk_10MHz) begin
        if (pad_latch) begin
            sh0 <= ~pressed0;
            sh1 <= ~pressed1;
        end else begin
            if (pad_clk[0] && !padPrev[0]) sh0 <= {1'b1, sh0[7:1]};
            if (pad_clk[1] && !padPrev[1]) sh1 <= {1'b1, sh1[7:1]};
        end
        padPrev <= pad_clk;
    end

    assign pad_data = {sh1[0], sh0[0]};

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: got 0x%0h, wanted 0x%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Monitor: pops one expectation per valid strobe and tracks clock, overlap and overrun activity.
    always @(negedge clk_10MHz) begin
        exp_t e;
        if (pad_clk[0] && !monPrev[0]) rise0++;
        if (pad_clk[1] && !monPrev[1]) rise1++;
        if (pad_clk == 2'b11) overlapCount++;
        if (poll_overrun) begin
            overrunCount++;
            overrunCycle = cyc;
        end
        monPrev <= pad_clk;
        for (int p = 0; p < 2; p++) begin
            if (valid[p]) begin
                if (p == 1) v1Count++;
                if (expQ.size() == 0) begin
                    nChecks++;
                    nFails++;
                    $display("[TB] FAIL unexpected_valid: got valid[%0d] at cycle %0d, wanted none", p, cyc);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("valid_port", p, e.port);
                    checkOutput("valid_cycle", cyc, e.cycle);
                    checkOutput((p == 0) ? "buttons0" : "buttons1", (p == 0) ? buttons0 : buttons1, e.value);
                end
            end
        end
    end

    task automatic pushPoll(input int t, input logic [7:0] v0, input logic [7:0] v1);
        expQ.push_back('{port: 0, value: v0, cycle: t + V0_LAT});
        expQ.push_back('{port: 1, value: v1, cycle: t + V1_LAT});
    endtask

    task automatic pulseForce(output int t);
        t = cyc;
        force_poll = 1'b1;
        @(negedge clk_10MHz);
        force_poll = 1'b0;
    endtask

    task automatic applyStimulus(input logic [7:0] p0, input logic [7:0] p1, output int t);
        pressed0 = p0;
        pressed1 = p1;
        pushPoll(cyc, p0, p1);
        pulseForce(t);
    endtask

    task automatic waitUntil(input int target);
        while (cyc < target) @(negedge clk_10MHz);
    endtask

    task automatic waitIdle(input int bound, input string name);
        int n = 0;
        @(negedge clk_10MHz);
        while (busy && n < bound) begin
            @(negedge clk_10MHz);
            n++;
        end
        checkOutput(name, busy, 1'b0);
    endtask

    task automatic restartTimer(output int c0);
        @(negedge clk_10MHz);
        enable = 1'b0;
        @(negedge clk_10MHz);
        enable = 1'b1;
        c0 = cyc;
    endtask

    task automatic clearCounters();
        rise0        = 0;
        rise1        = 0;
        overlapCount = 0;
        overrunCount = 0;
        overrunCycle = -1;
        v1Count      = 0;
    endtask

    initial begin
        #1_000_000_000;
        $display("[TB] FAIL watchdog: got timeout, wanted completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int t, t2, c0, rel, bad;
        logic [4:0] latchBits;

        // Reset and first timer poll
        #10 reset = 1'b0;
        enable   = 1'b1;
        pressed0 = 8'h01;
        pressed1 = 8'h02;
        repeat (5) @(negedge clk_10MHz);
        checkOutput("reset_outputs", {pad_latch, pad_clk, buttons0, buttons1, valid, busy, poll_overrun}, 0);
        reset = 1'b1;
        rel   = cyc;
        pushPoll(rel + POLL_DIV - 1, 8'h01, 8'h02);
        bad = 0;
        while (cyc < rel + POLL_DIV - 1) begin
            @(negedge clk_10MHz);
            if ({pad_latch, pad_clk, buttons0, buttons1, valid, busy, poll_overrun} != 0) bad++;
        end
        checkOutput("quiet_until_wrap", bad, 0);
        @(negedge clk_10MHz);
        checkOutput("timer_poll_start", {pad_latch, busy}, 2'b11);
        waitIdle(200, "timer_poll_idle");

        // Basic forced poll
        restartTimer(c0);
        clearCounters();
        applyStimulus(8'h09, 8'h80, t);
        latchBits = '0;
        for (int k = 0; k < 5; k++) begin
            waitUntil(t + 1 + k);
            latchBits[k] = pad_latch;
        end
        checkOutput("latch_window", latchBits, 5'b01111);
        waitIdle(200, "basic_idle");
        checkOutput("busy_end_cycle", cyc - t, 70);
        checkOutput("clk_pulses_p0", rise0, 8);
        checkOutput("clk_pulses_p1", rise1, 8);
        checkOutput("clk_overlap", overlapCount, 0);
        checkOutput("basic_no_overrun", overrunCount, 0);

        // Overrun
        restartTimer(c0);
        clearCounters();
        applyStimulus(8'h5A, 8'hC3, t);
        waitUntil(t + 10);
        pulseForce(t2);
        waitUntil(t + 20);
        pulseForce(t2);
        pushPoll(t + V1_LAT, 8'h5A, 8'hC3);
        waitUntil(t + V1_LAT);
        checkOutput("chain_busy_done", busy, 1'b1);
        @(negedge clk_10MHz);
        checkOutput("chain_latch", {pad_latch, busy}, 2'b11);
        waitIdle(300, "overrun_idle");
        checkOutput("overrun_idle_cycle", cyc - t, 2 * V1_LAT + 1);
        checkOutput("overrun_count", overrunCount, 1);
        checkOutput("overrun_cycle", overrunCycle - t, 21);

        // Timer wrap and force_poll together
        restartTimer(c0);
        clearCounters();
        waitUntil(c0 + POLL_DIV - 1);
        applyStimulus(8'hFF, 8'h00, t);
        waitIdle(300, "simul_idle");
        checkOutput("simul_single_poll", v1Count, 1);
        checkOutput("simul_no_overrun", overrunCount, 0);

        // enable falls mid-poll
        restartTimer(c0);
        clearCounters();
        applyStimulus(8'h24, 8'h11, t);
        waitUntil(t + 10);
        enable = 1'b0;
        waitIdle(200, "disable_idle");
        checkOutput("disable_complete_cycle", cyc - t, 70);
        pulseForce(t2);
        bad = 0;
        repeat (POLL_DIV + 100) begin
            @(negedge clk_10MHz);
            if (busy || pad_latch) bad++;
        end
        checkOutput("disabled_quiet", bad, 0);
        checkOutput("buttons0_hold", buttons0, 8'h24);
        checkOutput("buttons1_hold", buttons1, 8'h11);

        // Reset mid-poll
        restartTimer(c0);
        clearCounters();
        pressed0 = 8'h0F;
        pressed1 = 8'hF0;
        pulseForce(t);
        waitUntil(t + 20);
        checkOutput("pre_reset_clk", {busy, pad_clk}, 3'b101);
        reset = 1'b0;
        #1;
        checkOutput("reset_mid_clk", pad_clk, 2'b00);
        checkOutput("reset_mid_busy", busy, 1'b0);
        checkOutput("reset_mid_latch", pad_latch, 1'b0);
        checkOutput("reset_mid_buttons", {buttons0, buttons1}, 16'h0000);
        repeat (3) @(negedge clk_10MHz);
        reset  = 1'b1;
        enable = 1'b0;
        repeat (100) @(negedge clk_10MHz);
        checkOutput("post_reset_idle", {busy, valid, buttons0, buttons1}, 0);

        checkOutput("scoreboard_drained", expQ.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFails);
        $finish;
    end

endmodule
